// File: rtl/trade_decider.sv
// -----------------------------------------------------------------------------
// trade_decider
//
// Scores one parsed market record at a time, decides BUY / SELL / HOLD /
// REJECT for the selected stock, tracks a per-stock holding flag and emits a
// two-byte response to a UART transmitter through a valid/ready handshake.
//
// Ports:
//   clk         single clock, all state changes on the rising edge
//   rst         asynchronous, active-high reset
//   data_ready  one-cycle pulse marking a valid record on stock/features
//   stock       one-hot stock select, bit i = stock index i+1
//   features    [7:0] company, [15:8] four, [23:16] profit, [31:24] twitter,
//               [39:32] moving, [43:40] cmd, [47:44] ignored
//   tx_valid    response byte available on tx_byte
//   tx_byte     response byte (byte0 = {decision, 2'b00, index}, byte1 = score[10:3])
//   tx_ready    transmitter accepts tx_byte when tx_valid && tx_ready
//   busy        high whenever the FSM is not in IDLE
//   position    per-stock holding flags, same bit order as stock
//   drop_cnt    records dropped while busy (saturates at 255)
//
// Build option:
//   TRADE_DECIDER_DROP_CNT_EN  when defined, drop_cnt counts dropped records;
//                              when undefined, no counter is built and
//                              drop_cnt is tied to 0.
//
// SELL_THRESH must be strictly below BUY_THRESH.
// -----------------------------------------------------------------------------
module trade_decider #(
    parameter logic [10:0] BUY_THRESH  = 11'd900,
    parameter logic [10:0] SELL_THRESH = 11'd400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_ready,
    input  logic [10:0] stock,
    input  logic [47:0] features,
    output logic        tx_valid,
    output logic [7:0]  tx_byte,
    input  logic        tx_ready,
    output logic        busy,
    output logic [10:0] position,
    output logic [7:0]  drop_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SCORE  = 3'd1;
    localparam logic [2:0] S_DECIDE = 3'd2;
    localparam logic [2:0] S_SEND0  = 3'd3;
    localparam logic [2:0] S_SEND1  = 3'd4;

    localparam logic [1:0] DEC_HOLD   = 2'b00;
    localparam logic [1:0] DEC_BUY    = 2'b01;
    localparam logic [1:0] DEC_SELL   = 2'b10;
    localparam logic [1:0] DEC_REJECT = 2'b11;

    logic [2:0]  state;
    logic [10:0] stock_q;
    logic [43:0] feat_q;
    logic [10:0] score_q;

    // Upper nibble of the record carries nothing for this block.
    logic unused_bits;
    assign unused_bits = ^features[47:44];

    // Field views of the latched record.
    logic [7:0] company, four, profit, twitter, moving;
    logic [3:0] cmd;
    assign company = feat_q[7:0];
    assign four    = feat_q[15:8];
    assign profit  = feat_q[23:16];
    assign twitter = feat_q[31:24];
    assign moving  = feat_q[39:32];
    assign cmd     = feat_q[43:40];

    // Worst case 255*6 = 1530 fits in 11 bits, so no carry is lost.
    logic [10:0] score_sum;
    assign score_sum = {3'b000, company} + {3'b000, four} + {2'b00, profit, 1'b0}
                     + {3'b000, twitter} + {3'b000, moving};

    assign busy = (state != S_IDLE);

    // Decision logic, evaluated from latched stock and registered score.
    logic        is_onehot;
    logic        held;
    logic [1:0]  decision;
    logic [3:0]  stock_idx;
    logic [10:0] pos_next;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned; that is what keeps it free of latches.
        decision  = DEC_HOLD;
        stock_idx = 4'd0;
        pos_next  = position;
        // x & (x-1) clears the lowest set bit; zero result means at most one bit.
        is_onehot = (stock_q != 11'd0) && ((stock_q & (stock_q - 11'd1)) == 11'd0);
        held      = |(position & stock_q);

        if (!is_onehot) begin
            decision = DEC_REJECT;
        end else begin
            for (int i = 0; i < 11; i++) begin
                if (stock_q[i]) stock_idx = 4'(i + 1);
            end

            case (cmd)
                4'd1: decision = DEC_BUY;
                4'd2: decision = DEC_SELL;
                4'd3: begin
                    decision = DEC_HOLD;
                    pos_next = position & ~stock_q;
                end
                default: begin
                    if (score_q >= BUY_THRESH)       decision = DEC_BUY;
                    else if (score_q <= SELL_THRESH) decision = DEC_SELL;
                    else                             decision = DEC_HOLD;
                end
            endcase

            // Cannot buy what is already held, nor sell what is not held;
            // applies equally to forced commands.
            if (decision == DEC_BUY && held)   decision = DEC_HOLD;
            if (decision == DEC_SELL && !held) decision = DEC_HOLD;

            if (decision == DEC_BUY)       pos_next = position | stock_q;
            else if (decision == DEC_SELL) pos_next = position & ~stock_q;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update together from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            stock_q  <= '0;
            feat_q   <= '0;
            score_q  <= '0;
            position <= '0;
            tx_valid <= 1'b0;
            tx_byte  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (data_ready) begin
                        stock_q <= stock;
                        feat_q  <= features[43:0];
                        state   <= S_SCORE;
                    end
                end
                S_SCORE: begin
                    score_q <= score_sum;
                    state   <= S_DECIDE;
                end
                S_DECIDE: begin
                    position <= pos_next;
                    tx_byte  <= {decision, 2'b00, stock_idx};
                    tx_valid <= 1'b1;
                    state    <= S_SEND0;
                end
                S_SEND0: begin
                    if (tx_ready) begin
                        tx_byte <= score_q[10:3];
                        state   <= S_SEND1;
                    end
                end
                S_SEND1: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

`ifdef TRADE_DECIDER_DROP_CNT_EN
    // A pulse seen outside IDLE (including the edge that finishes SEND1) is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (data_ready && busy && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`else
    assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_trade_decider.sv
// -----------------------------------------------------------------------------
// tb_trade_decider
//
// Directed-vector bench for trade_decider. Each test task drives its own
// records and compares the response bytes, position flags and status outputs
// against hand-computed values. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_trade_decider;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_ready;
    logic [10:0] stock;
    logic [47:0] features;
    logic        tx_valid;
    logic [7:0]  tx_byte;
    logic        tx_ready;
    logic        busy;
    logic [10:0] position;
    logic [7:0]  drop_cnt;

    int vectors = 0;
    int errors  = 0;

`ifdef TRADE_DECIDER_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    typedef struct {
        logic [10:0] s;
        logic [47:0] f;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [10:0] pos;
    } rec_t;

    always #5 clk = ~clk;

    trade_decider dut (
        .clk        (clk),
        .rst        (rst),
        .data_ready (data_ready),
        .stock      (stock),
        .features   (features),
        .tx_valid   (tx_valid),
        .tx_byte    (tx_byte),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .position   (position),
        .drop_cnt   (drop_cnt)
    );

    // Upper nibble set to junk to show it is ignored.
    function automatic logic [47:0] pack(input logic [3:0] c, input logic [7:0] co,
                                         input logic [7:0] fo, input logic [7:0] pr,
                                         input logic [7:0] tw, input logic [7:0] mv);
        return {4'hA, c, mv, tw, pr, fo, co};
    endfunction

    task automatic send_record(input logic [10:0] s, input logic [47:0] f);
        @(negedge clk);
        stock = s; features = f; data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
    endtask

    task automatic wait_valid(output int waited, output bit timed_out);
        waited = 0;
        while (!tx_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        timed_out = !tx_valid;
    endtask

    // Requires tx_ready=1; returns on the falling edge after the response ends.
    task automatic collect(output logic [7:0] b0, output logic [7:0] b1,
                           output int waited, output bit timed_out);
        wait_valid(waited, timed_out);
        b0 = tx_byte;
        @(negedge clk);
        b1 = tx_byte;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; data_ready = 1'b0; tx_ready = 1'b1; stock = '0; features = '0;
        repeat (2) @(negedge clk);
        vectors++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        vectors++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte: got %h want 00", tx_byte); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (position !== 11'h000) begin errors++; $display("FAIL reset_position: got %h want 000", position); end
        vectors++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL reset_drop_cnt: got %h want 00", drop_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_basic_buy();
        logic [7:0] b0, b1; int w; bit to;
        send_record(11'h001, pack(4'd0, 8'd200, 8'd200, 8'd200, 8'd100, 8'd100));
        collect(b0, b1, w, to);
        vectors++; if (to) begin errors++; $display("FAIL basic_timeout: got no tx_valid want tx_valid"); end
        vectors++; if (w !== 2) begin errors++; $display("FAIL basic_latency: got %0d want 2", w); end
        vectors++; if (b0 !== 8'h41) begin errors++; $display("FAIL basic_byte0: got %h want 41", b0); end
        vectors++; if (b1 !== 8'h7D) begin errors++; $display("FAIL basic_byte1: got %h want 7D", b1); end
        vectors++; if (position !== 11'h001) begin errors++; $display("FAIL basic_position: got %h want 001", position); end
        vectors++; if ({tx_valid, busy} !== 2'b00) begin errors++; $display("FAIL basic_idle_after: got %b want 00", {tx_valid, busy}); end
    endtask

    task automatic test_second_buy();
        logic [7:0] b0, b1; int w; bit to;
        send_record(11'h001, pack(4'd0, 8'd200, 8'd200, 8'd200, 8'd100, 8'd100));
        collect(b0, b1, w, to);
        vectors++; if (to) begin errors++; $display("FAIL second_timeout: got no tx_valid want tx_valid"); end
        vectors++; if (b0 !== 8'h01) begin errors++; $display("FAIL second_byte0: got %h want 01", b0); end
        vectors++; if (b1 !== 8'h7D) begin errors++; $display("FAIL second_byte1: got %h want 7D", b1); end
        vectors++; if (position !== 11'h001) begin errors++; $display("FAIL second_position: got %h want 001", position); end
    endtask

    task automatic test_low_score();
        logic [7:0] b0, b1; int w; bit to;
        // Forced buy with zero score to set position[10] first.
        send_record(11'h400, pack(4'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0));
        collect(b0, b1, w, to);
        vectors++; if ({to, b0, b1} !== {1'b0, 8'h4B, 8'h00}) begin errors++; $display("FAIL low_setup_bytes: got to=%b %h %h want to=0 4B 00", to, b0, b1); end
        vectors++; if (position !== 11'h401) begin errors++; $display("FAIL low_setup_position: got %h want 401", position); end
        send_record(11'h400, pack(4'd0, 8'd50, 8'd50, 8'd50, 8'd50, 8'd50));
        collect(b0, b1, w, to);
        vectors++; if (to) begin errors++; $display("FAIL low_timeout: got no tx_valid want tx_valid"); end
        vectors++; if (b0 !== 8'h8B) begin errors++; $display("FAIL low_byte0: got %h want 8B", b0); end
        vectors++; if (b1 !== 8'h25) begin errors++; $display("FAIL low_byte1: got %h want 25", b1); end
        vectors++; if (position !== 11'h001) begin errors++; $display("FAIL low_position: got %h want 001", position); end
    endtask

    task automatic test_invalid_stock();
        logic [7:0] b0, b1; int w; bit to;
        logic [10:0] bad [3];
        bad[0] = 11'h003; bad[1] = 11'h000; bad[2] = 11'h600;
        for (int i = 0; i < 3; i++) begin
            send_record(bad[i], pack(4'd1, 8'd200, 8'd200, 8'd200, 8'd100, 8'd100));
            collect(b0, b1, w, to);
            vectors++; if ({to, b0} !== {1'b0, 8'hC0}) begin errors++; $display("FAIL invalid_byte0[%0d]: got to=%b %h want to=0 C0", i, to, b0); end
            vectors++; if (position !== 11'h001) begin errors++; $display("FAIL invalid_position[%0d]: got %h want 001", i, position); end
        end
    endtask

    task automatic test_forced_cmds();
        logic [7:0] b0, b1; int w; bit to;
        rec_t rows [4];
        rows[0] = '{11'h001, pack(4'd3, 8'd200, 8'd200, 8'd200, 8'd100, 8'd100), 8'h01, 8'h7D, 11'h000};
        rows[1] = '{11'h002, pack(4'd2, 8'd200, 8'd200, 8'd200, 8'd100, 8'd100), 8'h02, 8'h7D, 11'h000};
        rows[2] = '{11'h002, pack(4'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0),           8'h42, 8'h00, 11'h002};
        rows[3] = '{11'h002, pack(4'd2, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255), 8'h82, 8'hBF, 11'h000};
        for (int i = 0; i < 4; i++) begin
            send_record(rows[i].s, rows[i].f);
            collect(b0, b1, w, to);
            vectors++; if ({to, b0, b1} !== {1'b0, rows[i].b0, rows[i].b1}) begin errors++; $display("FAIL forced_bytes[%0d]: got to=%b %h %h want to=0 %h %h", i, to, b0, b1, rows[i].b0, rows[i].b1); end
            vectors++; if (position !== rows[i].pos) begin errors++; $display("FAIL forced_position[%0d]: got %h want %h", i, position, rows[i].pos); end
        end
    endtask

    task automatic test_thresholds();
        logic [7:0] b0, b1; int w; bit to;
        rec_t rows [4];
        rows[0] = '{11'h002, pack(4'd4,  8'd255, 8'd255, 8'd194, 8'd1, 8'd0), 8'h02, 8'h70, 11'h000}; // 899
        rows[1] = '{11'h002, pack(4'd0,  8'd255, 8'd255, 8'd195, 8'd0, 8'd0), 8'h42, 8'h70, 11'h002}; // 900
        rows[2] = '{11'h002, pack(4'd15, 8'd201, 8'd200, 8'd0,   8'd0, 8'd0), 8'h02, 8'h32, 11'h002}; // 401
        rows[3] = '{11'h002, pack(4'd0,  8'd200, 8'd200, 8'd0,   8'd0, 8'd0), 8'h82, 8'h32, 11'h000}; // 400
        for (int i = 0; i < 4; i++) begin
            send_record(rows[i].s, rows[i].f);
            collect(b0, b1, w, to);
            vectors++; if ({to, b0, b1} !== {1'b0, rows[i].b0, rows[i].b1}) begin errors++; $display("FAIL thresh_bytes[%0d]: got to=%b %h %h want to=0 %h %h", i, to, b0, b1, rows[i].b0, rows[i].b1); end
            vectors++; if (position !== rows[i].pos) begin errors++; $display("FAIL thresh_position[%0d]: got %h want %h", i, position, rows[i].pos); end
        end
    endtask

    task automatic test_backpressure();
        int w; bit to; bit extra;
        tx_ready = 1'b0;
        send_record(11'h004, pack(4'd0, 8'd200, 8'd200, 8'd200, 8'd100, 8'd100));
        wait_valid(w, to);
        vectors++; if (to) begin errors++; $display("FAIL bp_timeout: got no tx_valid want tx_valid"); end
        for (int c = 0; c < 10; c++) begin
            data_ready = (c == 1 || c == 4 || c == 7);
            stock = 11'h008;
            features = pack(4'd2, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5);
            @(negedge clk);
            data_ready = 1'b0;
            vectors++; if ({tx_valid, tx_byte} !== {1'b1, 8'h43}) begin errors++; $display("FAIL bp_hold[%0d]: got %b %h want 1 43", c, tx_valid, tx_byte); end
        end
        vectors++; if (drop_cnt !== (DROP_EN ? 8'd3 : 8'd0)) begin errors++; $display("FAIL bp_drop_cnt: got %0d want %0d", drop_cnt, DROP_EN ? 3 : 0); end
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b want 1", busy); end
        tx_ready = 1'b1;
        @(negedge clk);
        vectors++; if ({tx_valid, tx_byte} !== {1'b1, 8'h7D}) begin errors++; $display("FAIL bp_byte1: got %b %h want 1 7D", tx_valid, tx_byte); end
        // This pulse lands on the edge that completes SEND1 and must be lost.
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        vectors++; if ({tx_valid, busy} !== 2'b00) begin errors++; $display("FAIL bp_done: got %b want 00", {tx_valid, busy}); end
        vectors++; if (drop_cnt !== (DROP_EN ? 8'd4 : 8'd0)) begin errors++; $display("FAIL bp_drop_cnt_send1: got %0d want %0d", drop_cnt, DROP_EN ? 4 : 0); end
        vectors++; if (position !== 11'h004) begin errors++; $display("FAIL bp_position: got %h want 004", position); end
        extra = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (tx_valid || busy) extra = 1'b1;
        end
        vectors++; if (extra !== 1'b0) begin errors++; $display("FAIL bp_single_response: got extra activity want none"); end
    endtask

    task automatic test_reset_mid_send();
        logic [7:0] b0, b1; int w; bit to;
        tx_ready = 1'b0;
        send_record(11'h010, pack(4'd0, 8'd200, 8'd200, 8'd200, 8'd100, 8'd100));
        wait_valid(w, to);
        vectors++; if ({to, position} !== {1'b0, 11'h014}) begin errors++; $display("FAIL rstmid_setup: got to=%b pos=%h want to=0 pos=014", to, position); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++; if ({tx_valid, busy} !== 2'b00) begin errors++; $display("FAIL rstmid_valid_busy: got %b want 00", {tx_valid, busy}); end
        vectors++; if (position !== 11'h000) begin errors++; $display("FAIL rstmid_position: got %h want 000", position); end
        vectors++; if ({tx_byte, drop_cnt} !== 16'h0000) begin errors++; $display("FAIL rstmid_byte_cnt: got %h want 0000", {tx_byte, drop_cnt}); end
        // Release together with a record: it must be taken on the first edge out of reset.
        @(negedge clk);
        rst = 1'b0; tx_ready = 1'b1;
        stock = 11'h001; features = pack(4'd1, 8'd50, 8'd50, 8'd50, 8'd50, 8'd50);
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        collect(b0, b1, w, to);
        vectors++; if ({to, w} !== {1'b0, 32'd2}) begin errors++; $display("FAIL rstmid_latency: got to=%b wait=%0d want to=0 wait=2", to, w); end
        vectors++; if (b0 !== 8'h41) begin errors++; $display("FAIL rstmid_byte0: got %h want 41", b0); end
        vectors++; if (b1 !== 8'h25) begin errors++; $display("FAIL rstmid_byte1: got %h want 25", b1); end
        vectors++; if (position !== 11'h001) begin errors++; $display("FAIL rstmid_position_after: got %h want 001", position); end
    endtask

    initial begin
        test_reset();
        test_basic_buy();
        test_second_buy();
        test_low_score();
        test_invalid_stock();
        test_forced_cmds();
        test_thresholds();
        test_backpressure();
        test_reset_mid_send();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
